// File: rtl/led_pio_pkg.sv
// Shared register map and constants for the LED output PIO.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_DUTY   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam int               DUTY_W     = 8;
  localparam logic [DUTY_W-1:0] DUTY_RESET = 8'hFF;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_RUN_BIT   = 1;

endpackage

// File: rtl/led_pio_blink_timer.sv
// Blink half-period down-counter and phase flip-flop; PERIOD == 0 halts with phase high.
module led_pio_blink_timer #(
  parameter int                  PERIOD_W     = 24,
  parameter logic [PERIOD_W-1:0] RESET_PERIOD = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                period_wr,
  input  logic [PERIOD_W-1:0] period_wdata,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;

  // A PERIOD write takes priority over the terminal-count reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= RESET_PERIOD;
      phase <= 1'b1;
    end else if (period_wr) begin
      cnt   <= period_wdata;
      phase <= 1'b1;
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == PERIOD_W'(1)) begin
      cnt   <= period;
      phase <= ~phase;
    end else if (cnt == '0) begin
      cnt   <= period;
    end else begin
      cnt   <= cnt - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/led_pio_ctrl.sv
// Avalon-MM LED output PIO with SET/CLR, blink mask and blink prescaler.
// Optional PWM dimming (DUTY register) enabled by defining LED_PIO_PWM_DIMMING_EN.
module led_pio_ctrl
  import led_pio_pkg::*;
#(
  parameter int                  WIDTH        = 32,
  parameter int                  PERIOD_W     = 24,
  parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
  parameter logic [PERIOD_W-1:0] RESET_PERIOD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic                wr;
  logic [WIDTH-1:0]    data_reg;
  logic [WIDTH-1:0]    blink_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic                period_wr;
  logic                phase;
  logic [WIDTH-1:0]    wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign period_wr = wr & (address == ADDR_PERIOD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg   <= RESET_VALUE;
      blink_reg  <= '0;
      period_reg <= RESET_PERIOD;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_reg   <= wd;
        ADDR_SET:    data_reg   <= data_reg | wd;
        ADDR_CLR:    data_reg   <= data_reg & ~wd;
        ADDR_BLINK:  blink_reg  <= wd;
        ADDR_PERIOD: period_reg <= writedata[PERIOD_W-1:0];
        default: ;
      endcase
    end
  end

  led_pio_blink_timer #(
    .PERIOD_W     (PERIOD_W),
    .RESET_PERIOD (RESET_PERIOD)
  ) u_blink_timer (
    .clk          (clk),
    .reset        (reset),
    .period       (period_reg),
    .period_wr    (period_wr),
    .period_wdata (writedata[PERIOD_W-1:0]),
    .phase        (phase)
  );

`ifdef LED_PIO_PWM_DIMMING_EN
  logic [DUTY_W-1:0] duty_reg;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              pwm_on;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_reg <= DUTY_RESET;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + DUTY_W'(1);
      if (wr && address == ADDR_DUTY)
        duty_reg <= writedata[DUTY_W-1:0];
    end
  end

  // Full-scale DUTY must be continuously on, not 255/256.
  assign pwm_on   = (pwm_cnt < duty_reg) | (duty_reg == DUTY_RESET);
  assign out_port = data_reg & (~blink_reg | {WIDTH{phase}}) & {WIDTH{pwm_on}};
`else
  assign out_port = data_reg & (~blink_reg | {WIDTH{phase}});
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]    = data_reg;
      ADDR_BLINK:  readdata[WIDTH-1:0]    = blink_reg;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_reg;
`ifdef LED_PIO_PWM_DIMMING_EN
      ADDR_DUTY:   readdata[DUTY_W-1:0]   = duty_reg;
`endif
      ADDR_STATUS: begin
        readdata[STATUS_PHASE_BIT] = phase;
        readdata[STATUS_RUN_BIT]   = (period_reg != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_pio_ctrl.sv
// Directed bench for led_pio_ctrl (WIDTH=8, RESET_VALUE=8'hA5); PWM checks when LED_PIO_PWM_DIMMING_EN is defined.
module tb_led_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  led_pio_ctrl #(
    .WIDTH        (8),
    .PERIOD_W     (24),
    .RESET_VALUE  (8'hA5),
    .RESET_PERIOD (24'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          cs;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge and
  // the task returns at the following falling edge.
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    int cnt;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    vecs[0]  = '{1'b1, 1'b1, 3'd0, 32'h0000000F, 3'd0, 32'h0F, 8'h0F};
    vecs[1]  = '{1'b1, 1'b1, 3'd1, 32'h00000030, 3'd0, 32'h3F, 8'h3F};
    vecs[2]  = '{1'b1, 1'b1, 3'd2, 32'h00000005, 3'd0, 32'h3A, 8'h3A};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 3'd1, 32'h00, 8'h3A};
    vecs[4]  = '{1'b1, 1'b1, 3'd1, 32'h000000C0, 3'd1, 32'h00, 8'hFA};
    vecs[5]  = '{1'b1, 1'b1, 3'd2, 32'h000000C0, 3'd2, 32'h00, 8'h3A};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 32'h00000000, 3'd0, 32'h3A, 8'h3A};
    vecs[7]  = '{1'b1, 1'b1, 3'd0, 32'hFFFFFF5A, 3'd0, 32'h5A, 8'h5A};
    vecs[8]  = '{1'b1, 1'b1, 3'd3, 32'hFFFF000F, 3'd3, 32'h0F, 8'h5A};
    vecs[9]  = '{1'b1, 1'b1, 3'd4, 32'hFF000000, 3'd4, 32'h00, 8'h5A};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 32'h00000000, 3'd6, 32'h01, 8'h5A};
    vecs[11] = '{1'b1, 1'b1, 3'd7, 32'hFFFFFFFF, 3'd7, 32'h00, 8'h5A};
    vecs[12] = '{1'b0, 1'b0, 3'd0, 32'h00000000, 3'd0, 32'h5A, 8'h5A};
    vecs[13] = '{1'b1, 1'b1, 3'd3, 32'h00000000, 3'd3, 32'h00, 8'h5A};
`ifdef LED_PIO_PWM_DIMMING_EN
    vecs[14] = '{1'b1, 1'b1, 3'd5, 32'h000000FF, 3'd5, 32'hFF, 8'h5A};
`else
    vecs[14] = '{1'b1, 1'b1, 3'd5, 32'h000000FF, 3'd5, 32'h00, 8'h5A};
`endif

    // Reset values while held and after release
    #1;
    check("rst_out", {24'h0, out_port}, 32'hA5);
    check("rst_data", readdata, 32'hA5);
    address = 3'd6;
    #1;
    check("rst_status", readdata, 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    address = 3'd0;
    #1;
    check("rel_out", {24'h0, out_port}, 32'hA5);
    check("rel_data", readdata, 32'hA5);

    // Register access table
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      address    = vecs[i].waddr;
      writedata  = vecs[i].wdata;
      chipselect = vecs[i].cs;
      write_n    = ~vecs[i].wr;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
    end

    // Blink: PERIOD=4 gives 4 cycles high, 4 low on bit0
    @(negedge clk);
    do_write(3'd0, 32'hFF);
    do_write(3'd3, 32'h01);
    do_write(3'd4, 32'd4);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("blink4_k%0d", k), {24'h0, out_port},
            {24'h0, 7'h7F, ((k / 4) % 2 == 0)});
      if (k < 15) @(negedge clk);
    end

    // Here the counter sits at 1 with phase low: rewrite PERIOD=2 on terminal count
    do_write(3'd4, 32'd2);
    address = 3'd6;
    for (int j = 0; j < 3; j++) begin
      #1;
      check($sformatf("rew2_out_j%0d", j), {24'h0, out_port}, {24'h0, 7'h7F, (j < 2)});
      check($sformatf("rew2_stat_j%0d", j), readdata, {30'h0, 1'b1, (j < 2)});
      if (j < 2) @(negedge clk);
    end

    // PERIOD=0 written while phase is low forces phase high
    do_write(3'd4, 32'd0);
    address = 3'd6;
    for (int m = 0; m < 4; m++) begin
      #1;
      check($sformatf("halt_out_m%0d", m), {24'h0, out_port}, 32'hFF);
      check($sformatf("halt_stat_m%0d", m), readdata, 32'h1);
      @(negedge clk);
    end

    // CLR write coinciding with a phase toggle: both take effect
    do_write(3'd4, 32'd2);
    #1;
    check("sim_pre0", {24'h0, out_port}, 32'hFF);
    @(negedge clk);
    #1;
    check("sim_pre1", {24'h0, out_port}, 32'hFF);
    do_write(3'd2, 32'h80);
    #1;
    check("sim_toggle", {24'h0, out_port}, 32'h7E);
    @(negedge clk);
    #1;
    check("sim_hold", {24'h0, out_port}, 32'h7E);
    @(negedge clk);
    #1;
    check("sim_back", {24'h0, out_port}, 32'h7F);

    // Asynchronous reset mid-period
    #2;
    reset = 1'b1;
    #1;
    address = 3'd6;
    #1;
    check("arst_out", {24'h0, out_port}, 32'hA5);
    check("arst_status", readdata, 32'h1);
    address = 3'd4;
    #1;
    check("arst_period", readdata, 32'h0);
    address = 3'd3;
    #1;
    check("arst_blink", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    address = 3'd6;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("arst_after_out", {24'h0, out_port}, 32'hA5);
      check("arst_after_stat", readdata, 32'h1);
    end

`ifdef LED_PIO_PWM_DIMMING_EN
    @(negedge clk);
    address = 3'd5;
    #1;
    check("duty_rst", readdata, 32'hFF);
    do_write(3'd0, 32'h01);
    do_write(3'd5, 32'd64);
    address = 3'd5;
    #1;
    check("duty_rd", readdata, 32'd64);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      cnt += int'(out_port[0]);
    end
    check("pwm64_cnt", cnt, 64);
    do_write(3'd5, 32'd0);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      cnt += int'(out_port[0]);
    end
    check("pwm0_cnt", cnt, 0);
    do_write(3'd5, 32'd255);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      cnt += int'(out_port[0]);
    end
    check("pwm255_cnt", cnt, 256);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
